moore_seq_det_param: RTL and testbench
======================================

// Module: moore_seq_det_param
// PURPOSE
//  Parametrised Moore sequence detector, successor to the fixed 10100 detectors.
//  - Matches a serial bit stream against an elaboration-time pattern of length N.
//  - Overlapping or non-overlapping detection, selected at run time.
//  - Input qualifier, saturating hit counter with synchronous clear.
//  - Used as a generic serial-pattern spotter, e.g. framing and sync-word detection.
// PARAMETERS
//  N        5          pattern length in bits, legal range 2..16
//  PATTERN  5'b10100   pattern, [N-1:0]; PATTERN[N-1] is the first bit received
//  CNT_W    8          hit counter width, >=1
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      x is valid this cycle; state advances only when en=1
//  x         in   1      serial data bit
//  ovl_mode  in   1      1 = overlapping, 0 = non-overlapping detection
//  clr_cnt   in   1      synchronous clear of hit_cnt and cnt_sat
//  y         out  1      Moore detect output, high while state == N
//  hit_cnt   out  CNT_W  number of detections since reset/clear, saturating
//  cnt_sat   out  1      sticky, set when hit_cnt saturates at all-ones
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=0, y=0, hit_cnt=0, cnt_sat=0. rst has priority over all inputs.
//  - Reset mid-match discards progress; the first post-reset bit starts from state 0.
//  - States S0..SN, width $clog2(N+1). Sk = the first k pattern bits are matched;
//    SN = detected.
//  - Failure table F[k], k=1..N: length of the longest proper prefix of the pattern
//    that is also a suffix of its first k bits. Computed at elaboration (function);
//    no hand-coded per-pattern case.
//  - Next state for k<N, with en=1 (KMP closure):
//    - x == expected bit p(k) -> Sk+1.
//    - otherwise follow F until a matching prefix extends, else S0.
//    - Must equal a hand-drawn Moore FSM, e.g. 10100: S4,x=1 -> S3; S2,x=0 -> S0.
//  - From SN with en=1:
//    - ovl_mode=1: behave as from S(F[N]).
//    - ovl_mode=0: behave as from S0.
//    - ovl_mode is sampled only on this transition.
//  - en=0: state, y and hit_cnt hold. y stays high if parked in SN.
//  - y = (state == N), registered-state decode only. No combinational path from x or en.
//    y rises in the cycle after the edge that samples the last pattern bit.
//  - A back-to-back re-entry of SN (e.g. all-ones pattern, overlap) keeps y high
//    and counts again.
//  - hit_cnt:
//    - +1 on each edge where en=1 and next state == SN; updates on the same edge as y.
//    - At all-ones it holds and cnt_sat is set.
//  - clr_cnt=1: hit_cnt=0 and cnt_sat=0 on the next edge. clr_cnt wins over a
//    simultaneous hit. State and y are unaffected.
//  - An illegal encoding (state > N) recovers to S0 on the next edge.
// TESTING
//  1. Default 10100 (MSB first), ovl=1, stream 1,0,1,0,1,0,0 ->
//     y=1 only in the cycle after bit 7; hit_cnt=1.
//  2. N=4, PATTERN=4'b1010, ovl=1, stream 1,0,1,0,1,0 ->
//     y pulses after bits 4 and 6; hit_cnt=2.
//  3. Same as 2 with ovl=0, stream 1,0,1,0,1,0,1,0 ->
//     y pulses after bits 4 and 8 only; hit_cnt=2.
//  4. Default pattern, stream 1,0,1 then en=0 for 3 cycles, then 0,0 ->
//     state holds while en=0; y pulses after the final 0.
//  5. CNT_W=2, N=4, PATTERN=4'b1111, ovl=1, six 1s ->
//     y high after bits 4..6; hit_cnt=3 with cnt_sat=1. Then clr_cnt coincident
//     with a hit -> hit_cnt=0, cnt_sat=0.
//  6. rst=1 asserted when in S4 of 10100, then 0 ->
//     y=0 and hit_cnt=0 next cycle; no detection until a full 10100 is received.

Source files
------------

// File: rtl/moore_seq_det_param_if.sv
// Bus bundle for the parametrised Moore sequence detector.
// Handshake: en is a plain valid qualifier with no ready -- the detector
// accepts every bit presented with en=1 on the rising clock edge, and
// ignores x/ovl_mode entirely while en=0.
interface moore_seq_det_param_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(N + 1);

  logic             en;
  logic             x;
  logic             ovl_mode;
  logic             clr_cnt;
  logic             y;
  logic [CNT_W-1:0] hit_cnt;
  logic             cnt_sat;
  logic [SW-1:0]    state_dbg;

  modport master (
    output en, x, ovl_mode, clr_cnt,
    input  y, hit_cnt, cnt_sat, state_dbg
  );

  modport slave (
    input  en, x, ovl_mode, clr_cnt,
    output y, hit_cnt, cnt_sat, state_dbg
  );
endinterface

// File: rtl/moore_seq_det_param.sv
// Parametrised Moore sequence detector with KMP-style transitions.
// State Sk means the first k pattern bits have been matched; SN is "detected".
// The next-state tables are built at elaboration from the pattern, so any
// pattern of length 2..16 works without a hand-written case statement.
module moore_seq_det_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b10100,
  parameter int             CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  moore_seq_det_param_if.slave   bus
);
  localparam int SW = $clog2(N + 1);
  localparam int TW = (N + 1) * SW;
  localparam logic [SW-1:0]    S_DET   = SW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pattern bit i in arrival order; PATTERN[N-1] arrives first.
  function automatic logic pbit(input int i);
    return 1'(PATTERN >> (N - 1 - i));
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of its first k bits.
  function automatic int fail_len(input int k);
    int   best;
    logic ok;
    best = 0;
    for (int len = 1; len < k; len++) begin
      ok = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (pbit(j) != pbit(k - len + j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  // Next state from Sk on bit b. From SN this walks F[N] first, which is
  // exactly the overlapping-mode behaviour.
  function automatic int next_of(input int k, input logic b);
    int   j;
    int   res;
    logic done;
    j    = k;
    res  = 0;
    done = 1'b0;
    for (int it = 0; it <= N; it++) begin
      if (!done) begin
        if (j < N) begin
          if (pbit(j) == b) begin
            res  = j + 1;
            done = 1'b1;
          end
        end
        if (!done) begin
          if (j == 0) begin
            res  = 0;
            done = 1'b1;
          end else begin
            j = fail_len(j);
          end
        end
      end
    end
    return res;
  endfunction

  // Packed table: entry k (SW bits at offset k*SW) is the successor of Sk on bit b.
  function automatic logic [TW-1:0] build_tab(input logic b);
    logic [TW-1:0] tab;
    tab = '0;
    for (int k = 0; k <= N; k++) begin
      tab = tab | (TW'(next_of(k, b)) << (k * SW));
    end
    return tab;
  endfunction

  localparam logic [TW-1:0] NXT0 = build_tab(1'b0);
  localparam logic [TW-1:0] NXT1 = build_tab(1'b1);

  logic [SW-1:0]    state_q;
  logic [SW-1:0]    state_d;
  logic [SW-1:0]    src;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             cnt_sat_q;

  // State register; reset discards any partial match.
  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  // Next-state: KMP step on qualified bits; SN restarts from S0 when non-overlapping;
  // an out-of-range encoding falls back to S0 regardless of en.
  always_comb begin
    state_d = state_q;
    src     = state_q;
    hit     = 1'b0;
    if (int'(state_q) > N) begin
      state_d = '0;
    end else if (bus.en) begin
      if (state_q == S_DET && !bus.ovl_mode) src = '0;
      if (bus.x) state_d = SW'(NXT1 >> (int'(src) * SW));
      else       state_d = SW'(NXT0 >> (int'(src) * SW));
      hit = (state_d == S_DET);
    end
  end

  // Outputs: pure decode of the registered state.
  always_comb begin
    bus.y         = (state_q == S_DET);
    bus.state_dbg = state_q;
  end

  // Saturating hit counter; clear beats a coincident hit, reset beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      cnt_sat_q <= 1'b0;
    end else if (bus.clr_cnt) begin
      hit_cnt_q <= '0;
      cnt_sat_q <= 1'b0;
    end else if (hit) begin
      if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (hit_cnt_q >= CNT_MAX - CNT_W'(1)) cnt_sat_q <= 1'b1;
    end
  end

  assign bus.hit_cnt = hit_cnt_q;
  assign bus.cnt_sat = cnt_sat_q;
endmodule

// File: tb/tb_moore_seq_det_param.sv
// Bench for moore_seq_det_param: three instances (10100/CNT_W=8, 1010/CNT_W=8,
// 1111/CNT_W=2) share one stimulus stream and are each compared against a
// bit-history reference model every cycle, plus directed expectations.
module tb_moore_seq_det_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic x   = 1'b0;
  logic ovl = 1'b1;
  logic clr = 1'b0;
  int   err = 0;
  int   chk = 0;

  // Clock
  always #5 clk = ~clk;

  moore_seq_det_param_if #(.N(5), .CNT_W(8)) ifa ();
  moore_seq_det_param_if #(.N(4), .CNT_W(8)) ifb ();
  moore_seq_det_param_if #(.N(4), .CNT_W(2)) ifc ();

  assign ifa.en = en;  assign ifa.x = x;  assign ifa.ovl_mode = ovl;  assign ifa.clr_cnt = clr;
  assign ifb.en = en;  assign ifb.x = x;  assign ifb.ovl_mode = ovl;  assign ifb.clr_cnt = clr;
  assign ifc.en = en;  assign ifc.x = x;  assign ifc.ovl_mode = ovl;  assign ifc.clr_cnt = clr;

  moore_seq_det_param #(.N(5), .PATTERN(5'b10100), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  moore_seq_det_param #(.N(4), .PATTERN(4'b1010),  .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  moore_seq_det_param #(.N(4), .PATTERN(4'b1111),  .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Observed {y, cnt_sat, hit_cnt(8), state(4)} per instance
  logic [13:0] act_pack [3];
  assign act_pack[0] = {ifa.y, ifa.cnt_sat, ifa.hit_cnt,         1'b0, ifa.state_dbg};
  assign act_pack[1] = {ifb.y, ifb.cnt_sat, ifb.hit_cnt,         1'b0, ifb.state_dbg};
  assign act_pack[2] = {ifc.y, ifc.cnt_sat, 6'b0, ifc.hit_cnt,   1'b0, ifc.state_dbg};

  // Reference model: the accepted bit history, matched as a whole string
  localparam int P_N   [3] = '{5, 4, 4};
  localparam int P_PAT [3] = '{'b10100, 'b1010, 'b1111};
  localparam int P_MAX [3] = '{255, 255, 3};

  int unsigned m_hist [3];
  int          m_hlen [3];
  int          m_cnt  [3];
  bit          m_y    [3];
  bit          m_sat  [3];

  // Matched-prefix length: N while detected, else longest history suffix that starts the pattern.
  function automatic int m_state(input int i);
    if (m_y[i]) return P_N[i];
    for (int l = P_N[i] - 1; l > 0; l--) begin
      if (l <= m_hlen[i] &&
          (m_hist[i] & ((32'd1 << l) - 1)) == (P_PAT[i] >> (P_N[i] - l)))
        return l;
    end
    return 0;
  endfunction

  function automatic void model_edge();
    bit hit;
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      if (rst) begin
        m_hist[i] = 0; m_hlen[i] = 0; m_y[i] = 1'b0; m_cnt[i] = 0; m_sat[i] = 1'b0;
      end else begin
        if (en) begin
          if (m_y[i] && !ovl) begin
            m_hist[i] = 0;
            m_hlen[i] = 0;
          end
          m_hist[i] = (m_hist[i] << 1) | 32'(x);
          if (m_hlen[i] < 32) m_hlen[i]++;
          m_y[i] = (m_hlen[i] >= P_N[i]) &&
                   ((m_hist[i] & ((32'd1 << P_N[i]) - 1)) == P_PAT[i]);
          hit = m_y[i];
        end
        if (clr) begin
          m_cnt[i] = 0;
          m_sat[i] = 1'b0;
        end else if (hit) begin
          if (m_cnt[i] < P_MAX[i]) m_cnt[i]++;
          if (m_cnt[i] == P_MAX[i]) m_sat[i] = 1'b1;
        end
      end
    end
  endfunction

  // Driver: apply inputs away from the edge, advance the model at the edge, settle.
  task automatic step(input logic e, input logic b, input logic o, input logic c);
    en = e; x = b; ovl = o; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk++;
      if (act_pack[i] !== 14'h0) begin
        err++;
        $display("FAIL reset dut%0d y/sat/cnt/state: got %h want %h", i, act_pack[i], 14'h0);
      end
    end
  endtask

  task automatic test_default_10100();
    bit s  [7] = '{1, 0, 1, 0, 1, 0, 0};
    bit ey [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [13:0] e;
    do_reset();
    for (int j = 0; j < 7; j++) begin
      step(1'b1, s[j], 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        e = {m_y[i], m_sat[i], 8'(m_cnt[i]), 4'(m_state(i))};
        chk++;
        if (act_pack[i] !== e) begin
          err++; $display("FAIL dflt dut%0d bit%0d: got %h want %h", i, j + 1, act_pack[i], e);
        end
      end
      chk++;
      if (ifa.y !== ey[j]) begin
        err++; $display("FAIL dflt_y bit%0d: got %b want %b", j + 1, ifa.y, ey[j]);
      end
    end
    chk++;
    if (ifa.hit_cnt !== 8'd1) begin
      err++; $display("FAIL dflt_cnt: got %0d want 1", ifa.hit_cnt);
    end
  endtask

  task automatic test_overlap_mode(input logic o);
    bit s  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit ey_ovl [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    bit ey_non [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [13:0] e;
    bit want;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      step(1'b1, s[j], o, 1'b0);
      for (int i = 0; i < 3; i++) begin
        e = {m_y[i], m_sat[i], 8'(m_cnt[i]), 4'(m_state(i))};
        chk++;
        if (act_pack[i] !== e) begin
          err++; $display("FAIL ovl%0b dut%0d bit%0d: got %h want %h", o, i, j + 1, act_pack[i], e);
        end
      end
      want = o ? ey_ovl[j] : ey_non[j];
      chk++;
      if (ifb.y !== want) begin
        err++; $display("FAIL ovl%0b_y bit%0d: got %b want %b", o, j + 1, ifb.y, want);
      end
    end
    chk++;
    if (ifb.hit_cnt !== (o ? 8'd3 : 8'd2)) begin
      err++; $display("FAIL ovl%0b_cnt: got %0d want %0d", o, ifb.hit_cnt, o ? 3 : 2);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk++;
      if (ifa.state_dbg !== 3'd3 || ifa.y !== 1'b0) begin
        err++; $display("FAIL en_hold cyc%0d: got state %0d y %b want state 3 y 0", j, ifa.state_dbg, ifa.y);
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk++;
    if (ifa.y !== 1'b0) begin
      err++; $display("FAIL en_pre_y: got %b want 0", ifa.y);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk++;
    if (ifa.y !== 1'b1 || ifa.hit_cnt !== 8'd1) begin
      err++; $display("FAIL en_det: got y %b cnt %0d want y 1 cnt 1", ifa.y, ifa.hit_cnt);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk++;
    if (ifa.y !== 1'b1 || ifa.hit_cnt !== 8'd1) begin
      err++; $display("FAIL en_park: got y %b cnt %0d want y 1 cnt 1", ifa.y, ifa.hit_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    bit ey [6] = '{0, 0, 0, 1, 1, 1};
    int ec [6] = '{0, 0, 0, 1, 2, 3};
    do_reset();
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk++;
      if (ifc.y !== ey[j] || int'(ifc.hit_cnt) != ec[j] || ifc.cnt_sat !== (j == 5)) begin
        err++;
        $display("FAIL sat bit%0d: got y %b cnt %0d sat %b want y %b cnt %0d sat %b",
                 j + 1, ifc.y, ifc.hit_cnt, ifc.cnt_sat, ey[j], ec[j], j == 5);
      end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk++;
    if (ifc.hit_cnt !== 2'd3 || ifc.cnt_sat !== 1'b1) begin
      err++; $display("FAIL sat_hold: got cnt %0d sat %b want cnt 3 sat 1", ifc.hit_cnt, ifc.cnt_sat);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk++;
    if (ifc.y !== 1'b1 || ifc.hit_cnt !== 2'd0 || ifc.cnt_sat !== 1'b0) begin
      err++; $display("FAIL clr_hit: got y %b cnt %0d sat %b want y 1 cnt 0 sat 0",
                      ifc.y, ifc.hit_cnt, ifc.cnt_sat);
    end
  endtask

  task automatic test_reset_mid_match();
    bit s [5] = '{1, 0, 1, 0, 0};
    do_reset();
    for (int j = 0; j < 4; j++) step(1'b1, s[j], 1'b1, 1'b0);
    chk++;
    if (ifa.state_dbg !== 3'd4) begin
      err++; $display("FAIL mid_s4: got state %0d want 4", ifa.state_dbg);
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk++;
    if (ifa.y !== 1'b0 || ifa.hit_cnt !== 8'd0 || ifa.state_dbg !== 3'd0) begin
      err++; $display("FAIL mid_rst: got y %b cnt %0d state %0d want 0 0 0", ifa.y, ifa.hit_cnt, ifa.state_dbg);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk++;
    if (ifa.y !== 1'b0) begin
      err++; $display("FAIL mid_nodet: got y %b want 0", ifa.y);
    end
    for (int j = 0; j < 5; j++) step(1'b1, s[j], 1'b1, 1'b0);
    chk++;
    if (ifa.y !== 1'b1 || ifa.hit_cnt !== 8'd1) begin
      err++; $display("FAIL mid_redet: got y %b cnt %0d want y 1 cnt 1", ifa.y, ifa.hit_cnt);
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    logic o;
    o = 1'b1;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) o = ~o;
      rst = ($urandom_range(0, 249) == 0);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), o, ($urandom_range(0, 39) == 0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        e = {m_y[i], m_sat[i], 8'(m_cnt[i]), 4'(m_state(i))};
        chk++;
        if (act_pack[i] !== e) begin
          err++; $display("FAIL rand dut%0d cyc%0d: got %h want %h", i, n, act_pack[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_10100();
    test_overlap_mode(1'b1);
    test_overlap_mode(1'b0);
    test_enable_hold();
    test_saturate_clear();
    test_reset_mid_match();
    test_random();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
